// File: rtl/usb_crc_pkg.sv
// ----------------------------------------------------------------------------
// usb_crc_pkg
// Shared constants and types for the serial USB CRC engine.
//   CRC5_*  : token CRC (x^5+x^2+1), reflected polynomial and good residual
//   CRC16_* : data CRC (x^16+x^15+x^2+1), reflected polynomial and residual
//   crc_state_e : engine control states
// ----------------------------------------------------------------------------
package usb_crc_pkg;

    localparam logic [4:0]  CRC5_POLY_R    = 5'h14;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h06;
    localparam logic [15:0] CRC16_POLY_R   = 16'hA001;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } crc_state_e;

endpackage

// File: rtl/usb_crc_lfsr_step.sv
// ----------------------------------------------------------------------------
// usb_crc_lfsr_step
// Combinational single-bit step of a right-shifting (reflected) CRC LFSR.
//   crc_in  : current register value
//   d       : incoming data bit (LSB-first wire order)
//   crc_out : (crc_in >> 1) ^ (fb ? POLY_R : 0), fb = crc_in[0] ^ d
// ----------------------------------------------------------------------------
module usb_crc_lfsr_step #(
    parameter int             W      = 5,
    parameter logic [W-1:0]   POLY_R = '0
) (
    input  logic [W-1:0] crc_in,
    input  logic         d,
    output logic [W-1:0] crc_out
);

    logic fb;
    assign fb = crc_in[0] ^ d;

    // Per-bit form: each bit takes its upper neighbour, the top bit takes 0,
    // and polynomial taps additionally fold in the feedback.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        if (gi == W - 1) begin : g_top
            assign crc_out[gi] = fb & POLY_R[gi];
        end else begin : g_mid
            assign crc_out[gi] = crc_in[gi+1] ^ (fb & POLY_R[gi]);
        end
    end

endmodule

// File: rtl/usb_crc_engine.sv
// ----------------------------------------------------------------------------
// usb_crc_engine
// Serial USB CRC generator/checker (CRC5 or CRC16 by parameter).
//   c, r            : clock, asynchronous active-low reset
//   start           : reload INIT and (re)enter ACCUM; aborts any emission
//   d, dv           : LSB-first data bit and its valid
//   emit            : from ACCUM, transmit ~crc serially
//   tx_ready        : downstream accepts tx_bit this cycle
//   eop             : from ACCUM, compare crc to RESIDUAL (result next cycle)
//   crc             : current register value
//   tx_bit/tx_valid : serial CRC output, held stable while tx_ready is low
//   tx_done         : one-cycle pulse after the last CRC bit is accepted
//   chk_valid       : one-cycle pulse, chk_ok is fresh
//   chk_ok          : residual matched at last eop; cleared by start
// Optional: define USB_CRC_ERRCNT_EN to add err_cnt[7:0], a saturating count
// of failed residual checks (cleared only by reset).
// ----------------------------------------------------------------------------
module usb_crc_engine
    import usb_crc_pkg::*;
#(
    parameter int           W        = 5,
    parameter logic [W-1:0] POLY_R   = W'(CRC5_POLY_R),
    parameter logic [W-1:0] INIT     = {W{1'b1}},
    parameter logic [W-1:0] RESIDUAL = W'(CRC5_RESIDUAL)
) (
    input  logic         c,
    input  logic         r,
    input  logic         start,
    input  logic         d,
    input  logic         dv,
    input  logic         emit,
    input  logic         tx_ready,
    input  logic         eop,
    output logic [W-1:0] crc,
    output logic         tx_bit,
    output logic         tx_valid,
    output logic         tx_done,
    output logic         chk_valid,
    output logic         chk_ok
`ifdef USB_CRC_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    localparam int CW = $clog2(W);

    crc_state_e   state_q, state_d;
    logic [W-1:0] crc_q, crc_d;
    logic [W-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         tx_done_q, tx_done_d;
    logic         chk_valid_q, chk_valid_d;
    logic         chk_ok_q, chk_ok_d;

    // A start cycle steps from INIT rather than the old register, so a bit
    // arriving together with start is the first bit of the new packet.
    logic [W-1:0] step_base;
    logic [W-1:0] step_out;
    logic [W-1:0] crc_upd;

    assign step_base = start ? INIT : crc_q;
    assign crc_upd   = dv ? step_out : step_base;

    usb_crc_lfsr_step #(
        .W      (W),
        .POLY_R (POLY_R)
    ) u_step (
        .crc_in  (step_base),
        .d       (d),
        .crc_out (step_out)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        tx_done_d   = 1'b0;
        chk_valid_d = 1'b0;
        chk_ok_d    = chk_ok_q;

        if (start) begin
            state_d  = ACCUM;
            crc_d    = crc_upd;
            chk_ok_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ACCUM: begin
                    crc_d = crc_upd;
                    if (emit) begin
                        state_d = EMIT;
                        sr_d    = ~crc_upd;
                        cnt_d   = '0;
                    end
                    if (eop) begin
                        chk_valid_d = 1'b1;
                        chk_ok_d    = (crc_upd == RESIDUAL);
                    end
                end
                EMIT: begin
                    if (tx_ready) begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(W - 1)) begin
                            state_d   = IDLE;
                            tx_done_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            sr_q        <= '0;
            cnt_q       <= '0;
            tx_done_q   <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            tx_done_q   <= tx_done_d;
            chk_valid_q <= chk_valid_d;
            chk_ok_q    <= chk_ok_d;
        end
    end

    // tx_valid decodes straight from the state flop so an asynchronous reset
    // drops it immediately, and a stall simply holds state and sr.
    assign crc       = crc_q;
    assign tx_valid  = (state_q == EMIT);
    assign tx_bit    = tx_valid & sr_q[0];
    assign tx_done   = tx_done_q;
    assign chk_valid = chk_valid_q;
    assign chk_ok    = chk_ok_q;

`ifdef USB_CRC_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counted in the same cycle the failing result is registered.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (chk_valid_d && !chk_ok_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_usb_crc_engine.sv
// ----------------------------------------------------------------------------
// tb_usb_crc_engine
// Drives a CRC5 and a CRC16 instance from the same stimulus and compares both
// against a polynomial-division reference model kept in the bench.
// ----------------------------------------------------------------------------
module tb_usb_crc_engine;
    import usb_crc_pkg::*;

    logic c = 1'b0;
    logic r, start, d, dv, emit, tx_ready, eop;

    logic [4:0]  crc5;
    logic        tx_bit5, tx_valid5, tx_done5, chk_valid5, chk_ok5;
    logic [15:0] crc16;
    logic        tx_bit16, tx_valid16, tx_done16, chk_valid16, chk_ok16;
`ifdef USB_CRC_ERRCNT_EN
    logic [7:0]  err_cnt5, err_cnt16;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit pkt[$];
    logic [15:0] last_m5, last_m16;

    always #5 c = ~c;

    usb_crc_engine #(.W(5), .POLY_R(CRC5_POLY_R), .INIT(5'h1F), .RESIDUAL(CRC5_RESIDUAL)) u_crc5 (
        .c(c), .r(r), .start(start), .d(d), .dv(dv), .emit(emit), .tx_ready(tx_ready), .eop(eop),
        .crc(crc5), .tx_bit(tx_bit5), .tx_valid(tx_valid5), .tx_done(tx_done5),
        .chk_valid(chk_valid5), .chk_ok(chk_ok5)
`ifdef USB_CRC_ERRCNT_EN
        , .err_cnt(err_cnt5)
`endif
    );

    usb_crc_engine #(.W(16), .POLY_R(CRC16_POLY_R), .INIT(16'hFFFF), .RESIDUAL(CRC16_RESIDUAL)) u_crc16 (
        .c(c), .r(r), .start(start), .d(d), .dv(dv), .emit(emit), .tx_ready(tx_ready), .eop(eop),
        .crc(crc16), .tx_bit(tx_bit16), .tx_valid(tx_valid16), .tx_done(tx_done16),
        .chk_valid(chk_valid16), .chk_ok(chk_ok16)
`ifdef USB_CRC_ERRCNT_EN
        , .err_cnt(err_cnt16)
`endif
    );

    // Reference: classic MSB-first polynomial division over the wire bits with
    // the normal (unreflected) generator, then bit-reversed to register form.
    function automatic logic [15:0] model_crc(input int w, input int n);
        logic [15:0] g, mask, rn, refl;
        logic top;
        mask = (w == 5) ? 16'h001F : 16'hFFFF;
        g    = (w == 5) ? 16'h0005 : 16'h8005;
        rn   = mask;
        for (int i = 0; i < n; i++) begin
            top = rn[w-1] ^ pkt[i];
            rn  = (rn << 1) & mask;
            if (top) rn = rn ^ g;
        end
        refl = '0;
        for (int i = 0; i < w; i++) refl[i] = rn[w-1-i];
        return refl;
    endfunction

    task automatic cyc(input logic st, input logic dd, input logic dvv, input logic em,
                       input logic rdy, input logic ep);
        start = st; d = dd; dv = dvv; emit = em; tx_ready = rdy; eop = ep;
        @(posedge c);
        @(negedge c);
    endtask

    task automatic load_string();
        logic [7:0] b;
        pkt.delete();
        for (int k = 0; k < 9; k++) begin
            b = 8'h31 + 8'(k);
            for (int i = 0; i < 8; i++) pkt.push_back(b[i]);
        end
    endtask

    task automatic append_crc(input int w);
        logic [15:0] m;
        m = model_crc(w, pkt.size());
        for (int i = 0; i < w; i++) pkt.push_back(~m[i]);
    endtask

    task automatic feed_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) cyc(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, pkt[i], 1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        r = 1'b0; start = 0; d = 0; dv = 0; emit = 0; tx_ready = 0; eop = 0;
        @(negedge c); @(negedge c);
        n_cmp++; if (crc5 !== 5'h1F) begin n_bad++; $display("FAIL reset_crc5 got %h want 1f", crc5); end
        n_cmp++; if (crc16 !== 16'hFFFF) begin n_bad++; $display("FAIL reset_crc16 got %h want ffff", crc16); end
        n_cmp++; if ({tx_bit5, tx_valid5, tx_done5, chk_valid5, chk_ok5} !== 5'b0) begin
            n_bad++; $display("FAIL reset_out5 got %b want 00000", {tx_bit5, tx_valid5, tx_done5, chk_valid5, chk_ok5}); end
        n_cmp++; if ({tx_bit16, tx_valid16, tx_done16, chk_valid16, chk_ok16} !== 5'b0) begin
            n_bad++; $display("FAIL reset_out16 got %b want 00000", {tx_bit16, tx_valid16, tx_done16, chk_valid16, chk_ok16}); end
`ifdef USB_CRC_ERRCNT_EN
        n_cmp++; if ({err_cnt5, err_cnt16} !== 16'h0) begin n_bad++; $display("FAIL reset_errcnt got %h/%h want 0", err_cnt5, err_cnt16); end
`endif
        r = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        $display("reset: done");
    endtask

    task automatic test_check_vector();
        logic [15:0] v5, v16, m5, m16;
        int n5, n16, last5, last16, done5, done16, nd5, nd16;
        v5 = '0; v16 = '0; n5 = 0; n16 = 0; last5 = -9; last16 = -9; done5 = -1; done16 = -1; nd5 = 0; nd16 = 0;
        cyc(1, 0, 0, 0, 1, 0);
        load_string();
        feed_range(0, 72, 1'b0);
        m5 = model_crc(5, 72); m16 = model_crc(16, 72);
        n_cmp++; if (crc5 !== m5[4:0]) begin n_bad++; $display("FAIL vec_crc5 got %h want %h", crc5, m5[4:0]); end
        n_cmp++; if (crc16 !== ~16'hB4C8) begin n_bad++; $display("FAIL vec_crc16 got %h want %h", crc16, ~16'hB4C8); end
        cyc(0, 0, 0, 1, 1, 0);
        for (int k = 0; k < 24; k++) begin
            if (tx_valid5)  begin if (n5 < 16)  v5[n5] = tx_bit5;   n5++;  last5 = k;  end
            if (tx_valid16) begin if (n16 < 16) v16[n16] = tx_bit16; n16++; last16 = k; end
            if (tx_done5)  begin nd5++;  done5 = k;  end
            if (tx_done16) begin nd16++; done16 = k; end
            cyc(0, 0, 0, 0, 1, 0);
        end
        n_cmp++; if (v5[4:0] !== 5'h19 || n5 != 5) begin n_bad++; $display("FAIL vec_tx5 got %h/%0d bits want 19/5", v5[4:0], n5); end
        n_cmp++; if (v16 !== 16'hB4C8 || n16 != 16) begin n_bad++; $display("FAIL vec_tx16 got %h/%0d bits want b4c8/16", v16, n16); end
        n_cmp++; if (nd5 != 1 || done5 != last5 + 1) begin n_bad++; $display("FAIL vec_done5 got %0d pulses at %0d want 1 at %0d", nd5, done5, last5 + 1); end
        n_cmp++; if (nd16 != 1 || done16 != last16 + 1) begin n_bad++; $display("FAIL vec_done16 got %0d pulses at %0d want 1 at %0d", nd16, done16, last16 + 1); end
        $display("check_vector: crc16 tx=%h crc5 tx=%h", v16, v5[4:0]);
    endtask

    task automatic test_residual();
        logic [15:0] m5, m16;
        // CRC5 codeword: last bit arrives together with eop
        cyc(1, 0, 0, 0, 1, 0);
        load_string(); append_crc(5);
        feed_range(0, 76, 1'b1);
        cyc(0, pkt[76], 1, 0, 1, 1);
        m5 = model_crc(5, 77); m16 = model_crc(16, 77);
        n_cmp++; if (chk_valid5 !== 1'b1 || chk_ok5 !== 1'b1) begin n_bad++; $display("FAIL res5_chk got v=%b ok=%b want 1/1", chk_valid5, chk_ok5); end
        n_cmp++; if (crc5 !== 5'h06) begin n_bad++; $display("FAIL res5_crc got %h want 06", crc5); end
        n_cmp++; if (chk_valid16 !== 1'b1 || chk_ok16 !== (m16 == 16'hB001)) begin
            n_bad++; $display("FAIL res5_chk16 got v=%b ok=%b want 1/%b", chk_valid16, chk_ok16, m16 == 16'hB001); end
        cyc(0, 0, 0, 0, 1, 0);
        n_cmp++; if (chk_valid5 !== 1'b0 || chk_ok5 !== 1'b1) begin n_bad++; $display("FAIL res5_hold got v=%b ok=%b want 0/1", chk_valid5, chk_ok5); end
        // CRC16 codeword: eop in its own cycle
        cyc(1, 0, 0, 0, 1, 0);
        load_string(); append_crc(16);
        feed_range(0, 88, 1'b0);
        cyc(0, 0, 0, 0, 1, 1);
        m5 = model_crc(5, 88);
        n_cmp++; if (chk_valid16 !== 1'b1 || chk_ok16 !== 1'b1) begin n_bad++; $display("FAIL res16_chk got v=%b ok=%b want 1/1", chk_valid16, chk_ok16); end
        n_cmp++; if (crc16 !== 16'hB001) begin n_bad++; $display("FAIL res16_crc got %h want b001", crc16); end
        n_cmp++; if (chk_ok5 !== (m5[4:0] == 5'h06)) begin n_bad++; $display("FAIL res16_chk5 got %b want %b", chk_ok5, m5[4:0] == 5'h06); end
        $display("residual: crc5=%h crc16=%h", 5'h06, crc16);
    endtask

    task automatic test_bad_packets();
        logic [15:0] m5, m16;
        int len, flip;
        for (int p = 0; p < 8; p++) begin
            cyc(1, 0, 0, 0, 1, 0);
            if (p == 0) begin
                load_string();
            end else begin
                pkt.delete();
                len = $urandom_range(8, 40);
                for (int i = 0; i < len; i++) pkt.push_back(1'($urandom));
            end
            append_crc(16);
            flip = -1;
            if (p == 0 || $urandom_range(0, 1) == 1) begin
                flip = $urandom_range(0, pkt.size() - 1);
                pkt[flip] = ~pkt[flip];
            end
            feed_range(0, pkt.size(), 1'b1);
            cyc(0, 0, 0, 0, 1, 1);
            m5 = model_crc(5, pkt.size()); m16 = model_crc(16, pkt.size());
            n_cmp++; if (crc16 !== m16 || crc5 !== m5[4:0]) begin
                n_bad++; $display("FAIL pkt%0d_crc got %h/%h want %h/%h", p, crc16, crc5, m16, m5[4:0]); end
            n_cmp++; if (chk_valid16 !== 1'b1 || chk_ok16 !== (m16 == 16'hB001)) begin
                n_bad++; $display("FAIL pkt%0d_chk16 got v=%b ok=%b want 1/%b", p, chk_valid16, chk_ok16, m16 == 16'hB001); end
            n_cmp++; if (chk_valid5 !== 1'b1 || chk_ok5 !== (m5[4:0] == 5'h06)) begin
                n_bad++; $display("FAIL pkt%0d_chk5 got v=%b ok=%b want 1/%b", p, chk_valid5, chk_ok5, m5[4:0] == 5'h06); end
            $display("packet %0d: len=%0d flip=%0d ok16=%b", p, pkt.size(), flip, m16 == 16'hB001);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] m5, m16;
        int idx5, idx16, len, stalls;
        bit d5, d16;
        logic rdy;
        idx5 = 0; idx16 = 0; d5 = 0; d16 = 0; stalls = 0;
        cyc(1, 0, 0, 0, 1, 0);
        pkt.delete();
        len = $urandom_range(16, 48);
        for (int i = 0; i < len; i++) pkt.push_back(1'($urandom));
        feed_range(0, len, 1'b1);
        m5 = model_crc(5, len); m16 = model_crc(16, len);
        last_m5 = m5; last_m16 = m16;
        cyc(0, 0, 0, 1, 1, 1);
        n_cmp++; if (chk_valid5 !== 1'b1 || chk_ok5 !== (m5[4:0] == 5'h06)) begin
            n_bad++; $display("FAIL bp_chk5 got v=%b ok=%b want 1/%b", chk_valid5, chk_ok5, m5[4:0] == 5'h06); end
        n_cmp++; if (chk_valid16 !== 1'b1 || chk_ok16 !== (m16 == 16'hB001)) begin
            n_bad++; $display("FAIL bp_chk16 got v=%b ok=%b want 1/%b", chk_valid16, chk_ok16, m16 == 16'hB001); end
        for (int k = 0; k < 300 && !(d5 && d16); k++) begin
            if (tx_done5) begin
                d5 = 1;
                n_cmp++; if (idx5 != 5) begin n_bad++; $display("FAIL bp_done5 got %0d bits want 5", idx5); end
            end
            if (tx_done16) begin
                d16 = 1;
                n_cmp++; if (idx16 != 16) begin n_bad++; $display("FAIL bp_done16 got %0d bits want 16", idx16); end
            end
            rdy = 1'($urandom);
            if (tx_valid5) begin
                n_cmp++;
                if (idx5 >= 5 || tx_bit5 !== ~m5[idx5] || crc5 !== m5[4:0]) begin
                    n_bad++; $display("FAIL bp_bit5 idx %0d got %b crc %h want %b crc %h", idx5, tx_bit5, crc5, ~m5[idx5 % 16], m5[4:0]); end
                if (rdy) idx5++;
            end
            if (tx_valid16) begin
                n_cmp++;
                if (idx16 >= 16 || tx_bit16 !== ~m16[idx16] || crc16 !== m16) begin
                    n_bad++; $display("FAIL bp_bit16 idx %0d got %b crc %h want %b crc %h", idx16, tx_bit16, crc16, ~m16[idx16 % 16], m16); end
                if (rdy) idx16++;
            end
            if (!rdy) stalls++;
            cyc(0, 0, 0, 0, rdy, 0);
        end
        n_cmp++; if (!(d5 && d16)) begin n_bad++; $display("FAIL bp_timeout got done5=%b done16=%b want 1/1", d5, d16); end
        $display("backpressure: len=%0d stalls=%0d bits16=%0d bits5=%0d", len, stalls, idx16, idx5);
    endtask

    task automatic test_idle_and_start_dv();
        logic [15:0] m16;
        // IDLE ignores dv, emit and eop
        cyc(0, 1, 1, 1, 1, 1);
        n_cmp++; if (crc5 !== last_m5[4:0] || crc16 !== last_m16) begin
            n_bad++; $display("FAIL idle_crc got %h/%h want %h/%h", crc5, crc16, last_m5[4:0], last_m16); end
        n_cmp++; if ({tx_valid5, chk_valid5, tx_valid16, chk_valid16} !== 4'b0) begin
            n_bad++; $display("FAIL idle_out got %b want 0000", {tx_valid5, chk_valid5, tx_valid16, chk_valid16}); end
        cyc(1, 1, 1, 0, 1, 0);
        pkt.delete(); pkt.push_back(1'b1);
        m16 = model_crc(16, 1);
        n_cmp++; if (crc5 !== 5'h0F) begin n_bad++; $display("FAIL start_dv5 got %h want 0f", crc5); end
        n_cmp++; if (crc16 !== m16) begin n_bad++; $display("FAIL start_dv16 got %h want %h", crc16, m16); end
        $display("start_dv: crc5=%h crc16=%h", crc5, crc16);
    endtask

    task automatic test_abort();
        int ndone, nvalid;
        ndone = 0; nvalid = 0;
        cyc(1, 0, 0, 0, 1, 0);
        load_string(); append_crc(5);
        feed_range(0, 76, 1'b0);
        cyc(0, pkt[76], 1, 1, 1, 1);
        n_cmp++; if (chk_ok5 !== 1'b1 || tx_valid5 !== 1'b1 || tx_valid16 !== 1'b1) begin
            n_bad++; $display("FAIL abort_pre got ok5=%b v5=%b v16=%b want 1/1/1", chk_ok5, tx_valid5, tx_valid16); end
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        n_cmp++; if (crc5 !== 5'h1F || crc16 !== 16'hFFFF) begin n_bad++; $display("FAIL abort_crc got %h/%h want 1f/ffff", crc5, crc16); end
        n_cmp++; if ({tx_valid5, tx_valid16, chk_ok5} !== 3'b0) begin
            n_bad++; $display("FAIL abort_out got %b want 000", {tx_valid5, tx_valid16, chk_ok5}); end
        cyc(0, 1, 1, 0, 1, 0);
        n_cmp++; if (crc5 !== 5'h0F) begin n_bad++; $display("FAIL abort_accum got %h want 0f", crc5); end
        for (int k = 0; k < 20; k++) begin
            ndone += int'(tx_done5) + int'(tx_done16);
            nvalid += int'(tx_valid5) + int'(tx_valid16);
            cyc(0, 0, 0, 0, 1, 0);
        end
        n_cmp++; if (ndone != 0 || nvalid != 0) begin n_bad++; $display("FAIL abort_quiet got done=%0d valid=%0d want 0/0", ndone, nvalid); end
        $display("abort: crc5=%h after restart", 5'h0F);
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1'($urandom), 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        n_cmp++; if (tx_valid5 !== 1'b1 || tx_valid16 !== 1'b1) begin n_bad++; $display("FAIL areset_pre got %b/%b want 1/1", tx_valid5, tx_valid16); end
        #2 r = 1'b0;
        #1;
        n_cmp++; if (tx_valid5 !== 1'b0 || tx_valid16 !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b/%b want 0/0", tx_valid5, tx_valid16); end
        n_cmp++; if (crc5 !== 5'h1F || crc16 !== 16'hFFFF) begin n_bad++; $display("FAIL areset_crc got %h/%h want 1f/ffff", crc5, crc16); end
        @(negedge c);
        r = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        $display("async_reset: tx_valid dropped before clock edge");
    endtask

`ifdef USB_CRC_ERRCNT_EN
    task automatic test_errcnt();
        r = 1'b0;
        @(negedge c);
        r = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        n_cmp++; if (err_cnt5 !== 8'h00 || err_cnt16 !== 8'h00) begin n_bad++; $display("FAIL errcnt_init got %h/%h want 00", err_cnt5, err_cnt16); end
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        n_cmp++; if (err_cnt5 !== 8'h01 || err_cnt16 !== 8'h01) begin n_bad++; $display("FAIL errcnt_one got %h/%h want 01", err_cnt5, err_cnt16); end
        for (int p = 0; p < 300; p++) begin
            cyc(1, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 1);
        end
        cyc(0, 0, 0, 0, 0, 0);
        n_cmp++; if (err_cnt5 !== 8'hFF || err_cnt16 !== 8'hFF) begin n_bad++; $display("FAIL errcnt_sat got %h/%h want ff", err_cnt5, err_cnt16); end
        $display("errcnt: 301 bad packets counted");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_check_vector();
        test_residual();
        test_bad_packets();
        test_backpressure();
        test_idle_and_start_dv();
        test_abort();
        test_async_reset();
`ifdef USB_CRC_ERRCNT_EN
        test_errcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
